serial_demux_8: RTL and testbench
=================================

// Module: serial_demux_8
// PURPOSE
//   Serial-to-parallel demultiplexer. Steers one input bit per accepted beat into
//   bit position sel of a shadow register, with sel driven by an internal counter.
//   Presents the assembled word after WIDTH beats.
//   Receive-side counterpart to the 8:1 mux datapath: a mux with a counting sel
//   serialises a word, and this block rebuilds it.
//   Sits between a single-bit link and any word-wide consumer.
// PARAMETERS
//   WIDTH      8   word width in bits; legal range 2..16; CNT_W = $clog2(WIDTH)
//   MSB_FIRST  0   0: first beat -> bit 0; 1: first beat -> bit WIDTH-1
// PORTS
//   clk         in   1        single clock; all state updates on its rising edge
//   rst_n       in   1        asynchronous active-low reset
//   en_n        in   1        active-low enable; 1 = freeze block (beats ignored)
//   sync        in   1        qualified by din_valid: this beat is bit 0 of a new frame
//   din         in   1        serial data bit
//   din_valid   in   1        din (and sync) valid this cycle
//   data        out  WIDTH    last completed word; held until next completion
//   data_valid  out  1        one-cycle pulse; data updated this cycle
//   busy        out  1        1 while a frame is partially received
//   sel         out  CNT_W    index of next beat (0..WIDTH-1)
//   parity_err  out  1        parity-fail pulse (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): data=0, data_valid=0, busy=0, sel=0, parity_err=0, shadow=0.
//     State = IDLE.
//     Reset mid-frame discards the partial word. data is also cleared.
//   Accepted beat: din_valid=1 and en_n=0 at a rising clk edge.
//     Anything else is no beat. State, sel and shadow hold when en_n=1: pause, not abort.
//   Bit placement: position p = MSB_FIRST ? WIDTH-1-sel : sel.
//     shadow[p] <= din; sel <= sel+1.
//   FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
//   IDLE  --accepted beat-->  SHIFT
//     The beat is stored as index 0; sel=1, busy=1.
//   SHIFT --accepted beat with sel==WIDTH-1--> last data bit.
//     Without the macro:
//       - go to IDLE; sel wraps to 0; busy=0.
//       - data <= completed word, including the bit on the same edge.
//       - data_valid=1 for exactly the next cycle.
//       - Latency: last beat edge -> data/data_valid visible 0 cycles after that edge.
//     With the macro: go to PARITY.
//   sync=1 on any accepted beat, any state:
//     - the beat is stored as index 0 and sel=1.
//     - the partial frame is discarded with no data_valid.
//     - state -> SHIFT.
//     - sync in IDLE is identical to a normal first beat.
//   No beat: data_valid and parity_err return to 0 the cycle after their pulse.
//     data holds its value.
//   Back-to-back frames: the beat after a completion is index 0 with no idle gap.
//     data_valid may pulse every WIDTH cycles.
//   sel is never >= WIDTH.
// CONFIGURATION
//   Macro: SERIAL_DEMUX_PARITY_EN
//   Defined:
//     - after WIDTH data beats the FSM enters PARITY and expects one extra beat.
//     - the extra beat carries even parity: ^{word, pbit} must be 0.
//     - on accept: data <= word and data_valid pulses.
//     - parity_err pulses together with data_valid when ^{word, pbit}==1.
//     - data is still updated on a parity failure.
//     - sync during PARITY behaves as above: the word is dropped with no pulse.
//     - sel reads WIDTH-1 while in PARITY.
//     - frame length = WIDTH+1 beats.
//   Undefined: no PARITY state; parity_err tied 0. The port always exists.
// TESTING
//   1 Reset: rst_n=0 mid-frame after 3 beats.
//     -> data=0, sel=0, busy=0 immediately.
//     -> the next 8 beats form a fresh word.
//   2 LSB-first: beats 1,0,1,0,0,1,0,1 with sync on the first.
//     -> data=8'hA5, data_valid for 1 cycle after the 8th edge.
//   3 en_n pause: 4 beats of 8'h3C, en_n=1 for 5 cycles with din_valid=1, 4 more beats.
//     -> data=8'h3C, exactly one data_valid.
//   4 Resync: 5 beats, then sync beat plus 7 beats of 8'hFF.
//     -> single data_valid, data=8'hFF.
//   5 Streaming MSB_FIRST=1: 8'h81 then 8'h7E back-to-back.
//     -> two data_valid pulses 8 cycles apart, values 8'h81 then 8'h7E.
//   6 Parity (macro on): 8'h07 with pbit=1 -> data_valid, parity_err=0.
//     8'h07 with pbit=0 -> data_valid and parity_err=1, data=8'h07.

Source files
------------

// File: rtl/serial_demux_8.sv
// serial_demux_8: serial-to-parallel demux steering one bit per beat into a shadow word via a counting sel.
// Optional trailing even-parity beat enabled by defining SERIAL_DEMUX_PARITY_EN.
module serial_demux_8 #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_n,
  input  logic             sync,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] sel,
  output logic             parity_err
);
`ifdef SERIAL_DEMUX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic perr;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, idx, pos;
  logic [WIDTH-1:0] shadow, shadow_nx;
  logic beat, start, done;
  assign beat = din_valid & ~en_n;
  // sync restarts the frame from any state, exactly like a first beat in IDLE
  assign start = sync | (state == IDLE);
  assign idx = start ? '0 : cnt;
  assign pos = MSB_FIRST ? LAST - idx : idx;
  assign busy = state != IDLE;
  assign sel = cnt;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    shadow_nx = shadow;
    done = 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
    perr = 1'b0;
`endif
    if (beat) begin
      if (start) begin
        shadow_nx[pos] = din;
        cnt_nx = CNT_W'(1);
        state_nx = SHIFT;
      end
`ifdef SERIAL_DEMUX_PARITY_EN
      else if (state == PARITY) begin
        done = 1'b1;
        perr = ^{shadow, din};
        cnt_nx = '0;
        state_nx = IDLE;
      end
`endif
      else if (cnt != LAST) begin
        shadow_nx[pos] = din;
        cnt_nx = cnt + 1'b1;
      end else begin
        shadow_nx[pos] = din;
`ifdef SERIAL_DEMUX_PARITY_EN
        state_nx = PARITY;
`else
        done = 1'b1;
        cnt_nx = '0;
        state_nx = IDLE;
`endif
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '0;
      data <= '0;
      data_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      shadow <= shadow_nx;
      data <= done ? shadow_nx : data;
      data_valid <= done;
    end
  end
`ifdef SERIAL_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else parity_err <= perr;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_demux_8.sv
// tb_serial_demux_8: table-driven bench for serial_demux_8 (LSB-first and MSB-first instances).
module tb_serial_demux_8;
  logic clk = 1'b0, rst_n = 1'b0, en_n = 1'b1, sync = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic [7:0] data, data1;
  logic data_valid, busy, parity_err, data_valid1, busy1, parity_err1;
  logic [2:0] sel, sel1;
  int pass = 0, total = 0;
  typedef struct {
    logic s, d, v, e;
    logic [7:0] data;
    logic dv, busy;
    logic [2:0] sel;
  } vec_t;
  vec_t tbl[$];
  serial_demux_8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .sync(sync), .din(din), .din_valid(din_valid),
    .data(data), .data_valid(data_valid), .busy(busy), .sel(sel), .parity_err(parity_err)
  );
  serial_demux_8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .sync(sync), .din(din), .din_valid(din_valid),
    .data(data1), .data_valid(data_valid1), .busy(busy1), .sel(sel1), .parity_err(parity_err1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic step(input logic s, input logic d, input logic v, input logic e);
    sync = s; din = d; din_valid = v; en_n = e;
    @(posedge clk);
    #1;
  endtask
  function automatic void add(input logic s, d, v, e, input logic [7:0] dt, input logic dv, bz, input logic [2:0] sl);
    tbl.push_back('{s, d, v, e, dt, dv, bz, sl});
  endfunction
  initial begin
    logic [7:0] w;
    #12;
    chk("reset data", data, 0);
    chk("reset data_valid", data_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset sel", sel, 0);
    chk("reset parity_err", parity_err, 0);
    @(negedge clk) rst_n = 1'b1;
`ifndef SERIAL_DEMUX_PARITY_EN
    w = 8'hA5;
    for (int i = 0; i < 8; i++) add(i == 0, w[i], 1, 0, i == 7 ? 8'hA5 : 8'h00, i == 7, i != 7, 3'(i + 1));
    add(0, 0, 0, 0, 8'hA5, 0, 0, 0);
    w = 8'h3C;
    for (int i = 0; i < 4; i++) add(i == 0, w[i], 1, 0, 8'hA5, 0, 1, 3'(i + 1));
    for (int i = 0; i < 5; i++) add(0, i[0], 1, 1, 8'hA5, 0, 1, 3'd4);
    for (int i = 4; i < 8; i++) add(0, w[i], 1, 0, i == 7 ? 8'h3C : 8'hA5, i == 7, i != 7, 3'(i + 1));
    add(0, 1, 0, 0, 8'h3C, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(i == 0, 0, 1, 0, 8'h3C, 0, 1, 3'(i + 1));
    add(0, 1, 0, 0, 8'h3C, 0, 1, 3'd5);
    for (int i = 0; i < 8; i++) add(i == 0, 1, 1, 0, i == 7 ? 8'hFF : 8'h3C, i == 7, i != 7, 3'(i + 1));
    add(0, 0, 0, 0, 8'hFF, 0, 0, 0);
    foreach (tbl[r]) begin
      step(tbl[r].s, tbl[r].d, tbl[r].v, tbl[r].e);
      chk($sformatf("row%0d data", r), data, tbl[r].data);
      chk($sformatf("row%0d data_valid", r), data_valid, tbl[r].dv);
      chk($sformatf("row%0d busy", r), busy, tbl[r].busy);
      chk($sformatf("row%0d sel", r), sel, tbl[r].sel);
      chk($sformatf("row%0d parity_err", r), parity_err, 0);
    end
    for (int i = 0; i < 16; i++) begin
      w = i < 8 ? 8'h81 : 8'h7E;
      step(i == 0, w[7 - (i % 8)], 1, 0);
      chk($sformatf("msb beat%0d data_valid", i), data_valid1, i == 7 || i == 15);
      if (i == 7 || i == 15) chk($sformatf("msb beat%0d data", i), data1, w);
    end
    step(0, 0, 0, 0);
    chk("msb after stream data_valid", data_valid1, 0);
    chk("msb after stream data", data1, 8'h7E);
    for (int i = 0; i < 3; i++) step(i == 0, 1, 1, 0);
    chk("pre-reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset data", data, 0);
    chk("async reset sel", sel, 0);
    chk("async reset busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    w = 8'h5A;
    for (int i = 0; i < 8; i++) step(0, w[i], 1, 0);
    chk("post-reset data", data, 8'h5A);
    chk("post-reset data_valid", data_valid, 1);
    chk("post-reset busy", busy, 0);
`else
    w = 8'h07;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) step(i == 0, w[i], 1, 0);
      chk($sformatf("par%0d sel in parity", k), sel, 3'd7);
      chk($sformatf("par%0d busy in parity", k), busy, 1);
      chk($sformatf("par%0d no early valid", k), data_valid, 0);
      step(0, k == 0, 1, 0);
      chk($sformatf("par%0d data_valid", k), data_valid, 1);
      chk($sformatf("par%0d data", k), data, 8'h07);
      chk($sformatf("par%0d parity_err", k), parity_err, k == 1);
      chk($sformatf("par%0d sel", k), sel, 0);
      step(0, 0, 0, 0);
      chk($sformatf("par%0d parity_err drop", k), parity_err, 0);
    end
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
